// File: rtl/quadram_arbiter_if.sv
// Request/grant bundle between the datapath requesters and the arbiter, plus the
// quadram pins the arbiter drives.
interface quadram_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 11
);
   logic [2:0]              req;
   logic [2:0]              lock;
   logic [3*ADDR_WIDTH-1:0] req_a;
   logic [11:0]             req_we;
   logic [95:0]             req_di;
   logic [2:0]              gnt;
   logic [2:0]              rvalid;
   logic [31:0]             rdata;
   logic                    en;
   logic [3:0]              we;
   logic [ADDR_WIDTH-1:0]   a;
   logic [31:0]             di;
   // RAM read data; "do" is a reserved word in SystemVerilog
   logic [31:0]             dout;

   modport master (
      output req, lock, req_a, req_we, req_di, dout,
      input  gnt, rvalid, rdata, en, we, a, di
   );

   modport slave (
      input  req, lock, req_a, req_we, req_di, dout,
      output gnt, rvalid, rdata, en, we, a, di
   );
endinterface

// File: rtl/quadram_arbiter.sv
// Three-requester round-robin arbiter with bounded locked bursts in front of one
// quadram port; registers the winner onto the RAM pins and steers read data back.
module quadram_arbiter #(
   parameter int unsigned ADDR_WIDTH = 11,
   parameter int unsigned LOCK_MAX   = 16
) (
   input logic              clk,
   input logic              rst,
   quadram_arbiter_if.slave bus
);

   localparam logic [7:0] LockMax = 8'(LOCK_MAX);

   typedef enum logic [1:0] {StIdle, StGrant, StLocked} state_e;

   state_e                state_q, state_d;
   logic [1:0]            ptr_q, ptr_d;
   logic [1:0]            own_q, own_d;
   logic [7:0]            lcnt_q, lcnt_d;
   logic                  en_q, en_d;
   logic [3:0]            we_q, we_d;
   logic [ADDR_WIDTH-1:0] a_q, a_d;
   logic [31:0]           di_q, di_d;
   logic [2:0]            rtag_q, rtag_d;
   logic [2:0]            rvalid_q, rvalid_d;

   logic                  win_vld;
   logic [1:0]            win;
   logic [1:0]            start;
   logic [1:0]            cand;
   logic [2:0]            mask;
   logic                  hold;
   logic [2:0]            win_oh;
   logic [3:0]            sel_we;
   logic [ADDR_WIDTH-1:0] sel_a;
   logic [31:0]           sel_di;

   function automatic logic [1:0] inc3(logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      own_d   = own_q;
      lcnt_d  = lcnt_q;
      win_vld = 1'b0;
      win     = 2'd0;
      start   = ptr_q;
      cand    = ptr_q;
      mask    = bus.req;
      hold    = (state_q == StLocked) && bus.req[own_q] && bus.lock[own_q] &&
                (lcnt_q < LockMax);
      if (hold) begin
         win_vld = 1'b1;
         win     = own_q;
         lcnt_d  = lcnt_q + 8'd1;
      end else begin
         // Release restarts the search after the holder; an exhausted holder sits out.
         if (state_q == StLocked) begin
            start = inc3(own_q);
            if (lcnt_q >= LockMax) mask[own_q] = 1'b0;
         end
         cand = start;
         for (int k = 0; k < 3; k++) begin
            if (!win_vld && mask[cand]) begin
               win_vld = 1'b1;
               win     = cand;
            end
            cand = inc3(cand);
         end
         lcnt_d = 8'd0;
         ptr_d  = start;
         if (win_vld && bus.lock[win]) begin
            state_d = StLocked;
            own_d   = win;
            lcnt_d  = 8'd1;
         end else if (win_vld) begin
            state_d = StGrant;
            ptr_d   = inc3(win);
         end else begin
            state_d = StIdle;
         end
      end
   end

   always_comb begin
      win_oh = 3'b001 << win;
      case (win)
         2'd1: begin
            sel_we = bus.req_we[7:4];
            sel_a  = bus.req_a[2*ADDR_WIDTH-1:ADDR_WIDTH];
            sel_di = bus.req_di[63:32];
         end
         2'd2: begin
            sel_we = bus.req_we[11:8];
            sel_a  = bus.req_a[3*ADDR_WIDTH-1:2*ADDR_WIDTH];
            sel_di = bus.req_di[95:64];
         end
         default: begin
            sel_we = bus.req_we[3:0];
            sel_a  = bus.req_a[ADDR_WIDTH-1:0];
            sel_di = bus.req_di[31:0];
         end
      endcase
   end

   always_comb begin
      en_d     = win_vld;
      we_d     = 4'b0000;
      a_d      = a_q;
      di_d     = di_q;
      rtag_d   = 3'b000;
      rvalid_d = rtag_q;
      if (win_vld) begin
         we_d   = sel_we;
         a_d    = sel_a;
         di_d   = sel_di;
         rtag_d = (sel_we == 4'b0000) ? win_oh : 3'b000;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         ptr_q    <= 2'd0;
         own_q    <= 2'd0;
         lcnt_q   <= 8'd0;
         en_q     <= 1'b0;
         we_q     <= 4'b0000;
         a_q      <= '0;
         di_q     <= 32'd0;
         rtag_q   <= 3'b000;
         rvalid_q <= 3'b000;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         own_q    <= own_d;
         lcnt_q   <= lcnt_d;
         en_q     <= en_d;
         we_q     <= we_d;
         a_q      <= a_d;
         di_q     <= di_d;
         rtag_q   <= rtag_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign bus.gnt    = (win_vld && !rst) ? win_oh : 3'b000;
   assign bus.rvalid = rvalid_q;
   assign bus.rdata  = bus.dout;
   assign bus.en     = en_q;
   assign bus.we     = we_q;
   assign bus.a      = a_q;
   assign bus.di     = di_q;

endmodule

// File: tb/tb_quadram_arbiter.sv
// Bench for quadram_arbiter: directed tables and sequences plus random traffic
// against a behavioural arbitration/memory model, with a small quadram model attached.
module tb_quadram_arbiter;

   localparam int unsigned AW = 11;
   localparam int unsigned LM = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   quadram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

   quadram_arbiter #(.ADDR_WIDTH(AW), .LOCK_MAX(LM)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Quadram stand-in: byte-write, read-first, one-cycle synchronous read.
   logic [31:0] mem [16];
   always_ff @(posedge clk) begin
      if (bus.en) begin
         for (int b = 0; b < 4; b++)
            if (bus.we[b]) mem[bus.a[3:0]][b*8 +: 8] <= bus.di[b*8 +: 8];
         bus.dout <= mem[bus.a[3:0]];
      end
   end

   typedef struct {
      int          due;
      int          id;
      logic [31:0] data;
      bit          known;
   } pend_t;

   typedef struct {
      logic [2:0] req;
      logic [2:0] lock;
      logic [2:0] gnt;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [AW-1:0] drv_a  [3];
   logic [3:0]    drv_we [3];
   logic [31:0]   drv_di [3];
   logic [2:0]    last_gnt;
   logic [2:0]    last_rv;
   logic [31:0]   last_rdata;

   // Reference model state
   int            m_ptr, m_own, m_cnt;
   logic [31:0]   ref_mem [16];
   bit            known [16];
   pend_t         pend [$];
   logic          exp_en;
   logic [3:0]    exp_we;
   logic [AW-1:0] exp_a;
   logic [31:0]   exp_di;

   vec_t tbl [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0;
      m_own = -1;
      m_cnt = 0;
      pend.delete();
      exp_en = 1'b0;
      exp_we = 4'b0000;
      exp_a  = '0;
      exp_di = 32'd0;
   endtask

   // Round-robin rules with bounded lock, written over plain integers.
   task automatic arb_model(input logic [2:0] r, input logic [2:0] l, output int win);
      int start;
      int excl;
      win = -1;
      if (m_own >= 0 && r[m_own] && l[m_own] && m_cnt < LM) begin
         win = m_own;
         m_cnt++;
         return;
      end
      start = (m_own >= 0) ? (m_own + 1) % 3 : m_ptr;
      excl  = (m_own >= 0 && m_cnt >= LM) ? m_own : -1;
      for (int k = 0; k < 3; k++) begin
         int i;
         i = (start + k) % 3;
         if (win < 0 && r[i] && i != excl) win = i;
      end
      m_own = -1;
      m_cnt = 0;
      m_ptr = start;
      if (win >= 0) begin
         if (l[win]) begin
            m_own = win;
            m_cnt = 1;
         end else begin
            m_ptr = (win + 1) % 3;
         end
      end
   endtask

   task automatic step(input logic [2:0] r, input logic [2:0] l);
      int         win;
      pend_t      ent;
      logic [2:0] exp_rv;
      logic [3:0] ad;
      logic [3:0] wv;
      @(negedge clk);
      bus.req  = r;
      bus.lock = l;
      for (int i = 0; i < 3; i++) begin
         bus.req_a[i*AW +: AW]  = drv_a[i];
         bus.req_we[i*4 +: 4]   = drv_we[i];
         bus.req_di[i*32 +: 32] = drv_di[i];
      end
      #1;
      arb_model(r, l, win);
      chk("gnt", 32'(bus.gnt), (win >= 0) ? 32'(1 << win) : 32'd0);
      chk("rvalid_onehot0", 32'($onehot0(bus.rvalid)), 32'd1);
      exp_rv = 3'b000;
      ent    = '{0, 0, 32'd0, 1'b0};
      if (pend.size() > 0 && pend[0].due == cyc) begin
         ent    = pend.pop_front();
         exp_rv = 3'b001 << ent.id;
      end
      chk("rvalid", 32'(bus.rvalid), 32'(exp_rv));
      if (exp_rv != 3'b000 && ent.known) chk("rdata", bus.rdata, ent.data);
      chk("en", 32'(bus.en), 32'(exp_en));
      chk("we", 32'(bus.we), 32'(exp_we));
      chk("a", 32'(bus.a), 32'(exp_a));
      chk("di", bus.di, exp_di);
      if (win >= 0) begin
         ad     = drv_a[win][3:0];
         wv     = drv_we[win];
         exp_en = 1'b1;
         exp_we = wv;
         exp_a  = drv_a[win];
         exp_di = drv_di[win];
         if (wv == 4'b0000) begin
            pend.push_back('{cyc + 2, win, ref_mem[ad], known[ad]});
         end else begin
            for (int b = 0; b < 4; b++)
               if (wv[b]) ref_mem[ad][b*8 +: 8] = drv_di[win][b*8 +: 8];
            known[ad] = known[ad] || (wv == 4'b1111);
         end
      end else begin
         exp_en = 1'b0;
         exp_we = 4'b0000;
      end
      last_gnt   = bus.gnt;
      last_rv    = bus.rvalid;
      last_rdata = bus.rdata;
      cyc++;
   endtask

   task automatic apply_reset();
      bus.req  = 3'b000;
      bus.lock = 3'b000;
      rst      = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // Round-robin from ptr 0, then lock limit with requester 2 locking.
      tbl[0]  = '{3'b111, 3'b000, 3'b001};
      tbl[1]  = '{3'b111, 3'b000, 3'b010};
      tbl[2]  = '{3'b111, 3'b000, 3'b100};
      tbl[3]  = '{3'b111, 3'b000, 3'b001};
      tbl[4]  = '{3'b111, 3'b000, 3'b010};
      tbl[5]  = '{3'b111, 3'b000, 3'b100};
      tbl[6]  = '{3'b100, 3'b100, 3'b100};
      tbl[7]  = '{3'b101, 3'b100, 3'b100};
      tbl[8]  = '{3'b101, 3'b100, 3'b100};
      tbl[9]  = '{3'b101, 3'b100, 3'b100};
      tbl[10] = '{3'b101, 3'b100, 3'b001};
      tbl[11] = '{3'b101, 3'b100, 3'b100};
      tbl[12] = '{3'b101, 3'b100, 3'b100};
      tbl[13] = '{3'b101, 3'b100, 3'b100};
      tbl[14] = '{3'b101, 3'b100, 3'b100};
      tbl[15] = '{3'b101, 3'b100, 3'b001};

      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = 32'd0;
         known[i]   = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
         drv_a[i]  = AW'(i);
         drv_we[i] = 4'b0000;
         drv_di[i] = 32'd0;
      end
      bus.req    = 3'b111;
      bus.lock   = 3'b000;
      bus.req_a  = '0;
      bus.req_we = '0;
      bus.req_di = '0;
      model_reset();

      // Reset values with requests pending
      #3;
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_en", 32'(bus.en), 32'd0);
      chk("rst_we", 32'(bus.we), 32'd0);
      chk("rst_a", 32'(bus.a), 32'd0);
      chk("rst_di", bus.di, 32'd0);
      chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
      apply_reset();

      // Single write then read via requester 1
      drv_a[1] = AW'(5); drv_we[1] = 4'b1111; drv_di[1] = 32'hDEADBEEF;
      step(3'b010, 3'b000);
      chk("single_wr_gnt", 32'(last_gnt), 32'h2);
      drv_we[1] = 4'b0000;
      step(3'b010, 3'b000);
      chk("single_rd_gnt", 32'(last_gnt), 32'h2);
      step(3'b000, 3'b000);
      step(3'b000, 3'b000);
      chk("single_rvalid", 32'(last_rv), 32'h2);
      chk("single_rdata", last_rdata, 32'hDEADBEEF);
      chk("a_hold", 32'(bus.a), 32'd5);

      // Byte enables via requester 0
      drv_a[0] = AW'(7); drv_we[0] = 4'b1111; drv_di[0] = 32'h11223344;
      step(3'b001, 3'b000);
      drv_we[0] = 4'b0101; drv_di[0] = 32'hAABBCCDD;
      step(3'b001, 3'b000);
      drv_we[0] = 4'b0000;
      step(3'b001, 3'b000);
      step(3'b000, 3'b000);
      step(3'b000, 3'b000);
      chk("byte_rvalid", 32'(last_rv), 32'h1);
      chk("byte_rdata", last_rdata, 32'h11BB33DD);

      // Table: round-robin and lock limit
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         drv_a[i]  = AW'(i + 8);
         drv_we[i] = 4'b0000;
      end
      for (int v = 0; v < 16; v++) begin
         step(tbl[v].req, tbl[v].lock);
         chk($sformatf("tbl%0d_gnt", v), 32'(last_gnt), 32'(tbl[v].gnt));
      end

      // Asynchronous reset in the middle of a read burst
      repeat (3) step(3'b111, 3'b000);
      #2 rst = 1'b1;
      #1;
      chk("midrst_gnt", 32'(bus.gnt), 32'd0);
      chk("midrst_en", 32'(bus.en), 32'd0);
      chk("midrst_we", 32'(bus.we), 32'd0);
      chk("midrst_rvalid", 32'(bus.rvalid), 32'd0);
      apply_reset();
      repeat (10) step(3'b000, 3'b000);

      // Voluntary lock release hands over to requester 1, then back to 0
      step(3'b011, 3'b001);
      chk("rel0_gnt", 32'(last_gnt), 32'h1);
      step(3'b011, 3'b001);
      step(3'b011, 3'b001);
      chk("rel2_gnt", 32'(last_gnt), 32'h1);
      step(3'b011, 3'b000);
      chk("rel_to1_gnt", 32'(last_gnt), 32'h2);
      step(3'b011, 3'b000);
      chk("rel_to0_gnt", 32'(last_gnt), 32'h1);
      step(3'b000, 3'b000);
      step(3'b000, 3'b000);

      // Random traffic against the model
      for (int n = 0; n < 1500; n++) begin
         logic [2:0] r;
         logic [2:0] l;
         for (int i = 0; i < 3; i++) begin
            drv_a[i]  = AW'($urandom_range(0, 15));
            drv_we[i] = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            drv_di[i] = $urandom;
         end
         r = 3'($urandom);
         l = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
         step(r, l);
      end
      repeat (3) step(3'b000, 3'b000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/quadram_arbiter.md
# quadram_arbiter

Three-requester round-robin arbiter that shares one quadram port (32-bit word, 4 byte-write enables, `ADDR_WIDTH` address, 1-cycle synchronous read) between datapath engines, e.g. `subsurf` pass logic, averager and host readout. Sits directly in front of a quadram instance. Registers the winning request onto the RAM pins and routes read data back to the issuing requester. Supports bounded locked bursts.

## Interface
- `ADDR_WIDTH`, 11, RAM word-address width
- `LOCK_MAX`, 16, maximum consecutive grants to one locked requester before forced release (2..255)
- `clk` input 1 — single clock, all logic on rising edge
- `rst` input 1 — asynchronous, active-high reset
- `req` input 3 — per-requester access request, bit i = requester i
- `lock` input 3 — per-requester burst-hold hint; only meaningful while the same `req` bit is high
- `req_a` input 3*`ADDR_WIDTH` — packed addresses, slice i = requester i
- `req_we` input 12 — packed byte write enables, 4 bits per requester; 0000 = read
- `req_di` input 96 — packed write data, 32 bits per requester
- `gnt` output 3 — one-hot or zero; combinational accept of the current cycle's request
- `rvalid` output 3 — one-hot or zero; read data valid for requester i
- `rdata` output 32 — read data, direct from `do`, qualified by `rvalid`
- `en` output 1 — RAM enable, registered
- `we` output 4 — RAM byte write enables, registered
- `a` output `ADDR_WIDTH` — RAM address, registered
- `di` output 32 — RAM write data, registered
- `do` input 32 — RAM read data

## Operation
- Arbitration is round-robin over a 2-bit priority pointer `ptr`. Search order is ptr, ptr+1, ptr+2 (mod 3). The first requester with `req` high wins.
- After a normal grant to i, `ptr` becomes i+1 mod 3.
- FSM states:
  - IDLE: no grant last cycle.
  - GRANT: unlocked grant last cycle.
  - LOCKED: holder `own`, count `lcnt`.
- Entering LOCKED: a grant to i with `lock[i]`=1 enters LOCKED with own=i and lcnt=1. `ptr` is not advanced.
- In LOCKED:
  - If `req[own]` && `lock[own]` && lcnt<`LOCK_MAX`: grant own and increment lcnt.
  - Otherwise: release. `ptr`=own+1, then arbitrate normally in the same cycle, excluding own if lcnt reached `LOCK_MAX`.
  - A forced release goes to GRANT or IDLE even if own still asserts `lock`.
- `lock` without `req` is ignored.
- Write grants (`req_we` slice ≠ 0) do not produce `rvalid`.
- The RAM stage registers `en`, `we`, `a`, `di` from the winner. With no winner: `en`=0 and `we`=0, while `a` and `di` hold their last values.
- A 1-deep tag pipeline records (read, requester) so `rvalid` is steered to the correct requester.

## Timing
- Reset (async, immediate):
  - `en`=0, `we`=0, `a`=0, `di`=0, `rvalid`=0.
  - ptr=0, state IDLE, lcnt=0.
  - `gnt`=0 while `rst` is high.
- Cycle N: requester drives `req`/`req_a`/`req_we`/`req_di`; `gnt[i]`=1 combinationally in N; request consumed at the N→N+1 edge.
- Cycle N+1: `en`/`a`/`we`/`di` present the access to the RAM. A write lands at the end of N+1.
- Cycle N+2: for a read, `rvalid[i]`=1 and `rdata`=`do`. Read latency is 2 cycles from grant.
- Requester without `gnt` holds its request stable; there is no retraction requirement, but a dropped `req` is simply not served.
- Throughput: one access per cycle, back-to-back across or within requesters.
- Read-after-write to the same address on consecutive grants returns the new data (the RAM write completes before the read edge).
- Worst-case wait for an unlocked requester with other requesters locking: 2*`LOCK_MAX`+2 cycles.
- Reset mid-operation:
  - In-flight `rvalid` is dropped and `en` is deasserted at once.
  - The first grant after reset deassertion goes to the lowest-index active requester.

## Test plan
- Reset/idle: assert `rst` mid-burst.
  - `en`, `we`, `rvalid` and `gnt` must go 0 asynchronously.
  - After release with `req`=000, outputs must stay 0 for 10 cycles.
- Single read: write 0xDEADBEEF at addr 5 via requester 1 (we=1111), then read addr 5 via requester 1.
  - Requires `gnt`=010 on both requests.
  - `rvalid`=010 two cycles after the read grant, with `rdata`=0xDEADBEEF.
- Round-robin: all three `req` high continuously with reads.
  - Grant sequence must be 0,1,2,0,1,2.
  - Each `rvalid` must arrive 2 cycles after the matching grant.
- Byte enables: write 0x11223344 at addr 7, then write 0xAABBCCDD with we=0101, then read addr 7.
  - Required `rdata`=0x11BB33DD.
- Lock limit (`LOCK_MAX`=4): requester 2 holds `req`+`lock` while requester 0 requests continuously.
  - Grants must be 2,2,2,2,0,2,2,2,2,0.
- Lock release and pointer: requester 0 locks for 3 cycles then drops `lock` with `req` still high, while requester 1 requests.
  - The next grant goes to 1, then to 0.
  - No cycle may show more than one `gnt` bit or more than one `rvalid` bit set.
